// File: rtl/mod_divisor_quinto_if.sv
// Handshake/data bundle for the fixed divide-by-5 unit.
//   start : request, taken when the divider is free to accept
//   a     : signed 9-bit dividend, captured on the accept edge
//   y     : low 6 bits of the signed quotient
//   r     : signed 4-bit remainder, -4..4, same sign as a or zero
//   of    : quotient outside -32..31
//   busy  : operation in progress, through the done cycle
//   done  : one-cycle pulse, y/r/of valid from this cycle on
interface mod_divisor_quinto_if;
  logic              start;
  logic signed [8:0] a;
  logic        [5:0] y;
  logic        [3:0] r;
  logic              of;
  logic              busy;
  logic              done;

  modport master (output start, a, input  y, r, of, busy, done);
  modport slave  (input  start, a, output y, r, of, busy, done);
endinterface

// File: rtl/mod_divisor_quinto.sv
// Signed divide-by-5, restoring, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any operation
//   bus : mod_divisor_quinto_if.slave (start/a in, y/r/of/busy/done out)
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start
// S_DIV  | 9 restoring steps on |a|, count 8..0
// S_SIGN | apply the sign of a, register y/r/of on the exit edge
// S_DONE | done pulse; start here is taken so ops run every 11 clocks
module mod_divisor_quinto (
  input  logic                 clk,
  input  logic                 rst,
  mod_divisor_quinto_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SIGN, S_DONE} state_t;

  state_t      state, state_next;
  logic        accept;

  logic [8:0]  mag;      // dividend shifts out the top, quotient bits shift in
  logic [3:0]  rem;
  logic [3:0]  cnt;
  logic        neg;

  logic [5:0]  y_q;
  logic [3:0]  r_q;
  logic        of_q;

  logic [8:0]  a_abs;
  logic [4:0]  shifted;
  logic        fits;
  logic [3:0]  rem_next;
  logic [9:0]  q_u;
  logic [3:0]  r_signed;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        accept     = 1'b1;
        state_next = S_DIV;
      end
      S_DIV:  if (cnt == 4'd0) state_next = S_SIGN;
      S_SIGN: state_next = S_DONE;
      S_DONE: begin
        // The done-exit edge doubles as the first idle edge, which is
        // what gives the 11-clock back-to-back cadence.
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_DIV;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // |-256| = 256 still fits as 9-bit unsigned.
  assign a_abs    = bus.a[8] ? (~bus.a + 9'd1) : bus.a;
  assign shifted  = {rem, mag[8]};
  assign fits     = (shifted >= 5'd5);
  assign rem_next = fits ? 4'(shifted - 5'd5) : shifted[3:0];

  // Quotient magnitude is at most 51, so 10 bits signed holds -51..51.
  assign q_u      = neg ? (~{1'b0, mag} + 10'd1) : {1'b0, mag};
  assign r_signed = neg ? (~rem + 4'd1) : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      mag   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      y_q   <= '0;
      r_q   <= '0;
      of_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        mag <= a_abs;
        neg <= bus.a[8];
        rem <= '0;
        cnt <= 4'd8;
      end else if (state == S_DIV) begin
        mag <= {mag[7:0], fits};
        rem <= rem_next;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
      if (state == S_SIGN) begin
        y_q  <= q_u[5:0];
        r_q  <= r_signed;
        of_q <= ($signed(q_u) > 10'sd31) || ($signed(q_u) < -10'sd32);
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.r    = r_q;
  assign bus.of   = of_q;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);

endmodule

// File: doc/mod_divisor_quinto.md
MOD_DIVISOR_QUINTO -- requirements
Module: mod_divisor_quinto

Interface
REQ-001 Parameters: none; divisor is the fixed constant 5, word widths are fixed.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request; sampled only in IDLE.
REQ-005 A  input  9  signed dividend, two's complement, -256..255; sampled on the START-accept edge.
REQ-006 Y  output  6  signed quotient, low 6 bits of the true quotient.
REQ-007 R  output  4  signed remainder, two's complement, -4..4.
REQ-008 OF  output  1  true quotient outside -32..31.
REQ-009 BUSY  output  1  high from the START-accept edge until the DONE cycle ends.
REQ-010 DONE  output  1  one-cycle pulse; Y, R and OF are valid from this cycle on.

Function
REQ-011 States: IDLE, DIV, SIGN, DONE; encoding is free; no other reachable states.
REQ-012 IDLE: START=1 at a rising edge -> latch |A| (9-bit unsigned, |-256|=256) and sign(A), clear partial remainder, iteration count=8, go to DIV.
REQ-013 DIV: restoring division by 5, one quotient bit per cycle, MSB first, 9 cycles (count 8..0) -> SIGN.
REQ-014 Partial remainder register is 4 bits unsigned (max 4 before shift), shifted value 5 bits; subtract 5 when shifted value >= 5.
REQ-015 SIGN: quotient magnitude is 0..51; negate quotient and remainder if A<0 (truncation toward zero; remainder carries the sign of A or is 0) -> DONE.
REQ-016 DONE: DONE=1 for exactly one cycle, BUSY=1 -> IDLE.
REQ-017 Latency: START accepted at edge k -> DONE high in the cycle following edge k+10; next START accepted at edge k+11 at the earliest.
REQ-018 Y = quotient[5:0]; OF=1 iff signed quotient >51-safe range check fails (q>31 or q<-32); Y wraps, no saturation.
REQ-019 Y, R, OF update only on the edge entering DONE; they hold until the next DONE, including through IDLE and the next DIV/SIGN.
REQ-020 START while BUSY=1 is ignored, with no effect on the operation or outputs; A changes after the accept edge have no effect.
REQ-021 START held high continuously: a new operation is accepted on each first IDLE edge (back-to-back every 11 cycles).
REQ-022 Identity: for A=5*k, k in -32..31 -> Y=k, R=0, OF=0 (inverse of the x5 block).

Reset
REQ-023 RST=1 at a rising edge -> state IDLE; Y=0, R=0, OF=0, BUSY=0, DONE=0; internal registers cleared.
REQ-024 RST overrides START and any in-flight operation (mid-DIV or SIGN): aborted, no DONE pulse, outputs zeroed.
REQ-025 The first edge with RST=0 is a normal IDLE edge; START may be accepted on it.

Verification
REQ-026 A=25, START pulse -> DONE after 11 edges; Y=6'h05, R=4'h0, OF=0; BUSY high for 11 cycles.
REQ-027 A=-7 -> Y=6'h3F (-1), R=4'hE (-2), OF=0.
REQ-028 A=155 -> Y=6'h1F, R=0, OF=0; A=160 -> Y=6'h20, R=0, OF=1; A=-256 -> Y=6'h0D (q=-51), R=4'hF (-1), OF=1.
REQ-029 START for A=25, then START with A=100 during DIV -> single DONE, Y=5; outputs unchanged until the next accepted START.
REQ-030 RST asserted during the 5th DIV cycle -> no DONE; all outputs 0 the cycle after; new START with A=-5 -> Y=6'h3F, R=0.
REQ-031 Sweep A=-256..255 -> Y, R, OF match A/5 truncated toward zero and A%5 per REQ-018; k=-32..31 satisfy REQ-022.
